// File: rtl/song_play_if.sv
// Board-side bundle of the song player: manual keys, play control, song ROM port and
// display/buzzer outputs. The master side is the board/ROM, the slave side is the sequencer.
interface song_play_if #(
    parameter int NOTE_ADDR_W = 6
);
    logic [6:0]             key_in;
    logic [3:0]             song_sel;
    logic                   start;
    logic                   stop;
    logic [NOTE_ADDR_W+1:0] rom_addr;
    logic [7:0]             rom_data;
    logic [6:0]             status;
    logic [3:0]             num;
    logic [3:0]             note_out;
    logic                   busy;
    logic                   done;

    modport master (
        output key_in, song_sel, start, stop, rom_data,
        input  rom_addr, status, num, note_out, busy, done
    );

    modport slave (
        input  key_in, song_sel, start, stop, rom_data,
        output rom_addr, status, num, note_out, busy, done
    );
endinterface

// File: rtl/song_play_ctrl.sv
// Piano display/buzzer sequencer: follows manual keys while idle, otherwise steps through
// a song ROM, holding each note for beats*BEAT_CYCLES cycles followed by a silent gap.
module song_play_ctrl #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int NOTE_ADDR_W = 6
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    song_play_if.slave bus
);
    localparam int BEAT_W = $clog2(15 * BEAT_CYCLES);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BEAT_W-1:0]      BEAT_K   = BEAT_W'(BEAT_CYCLES);
    localparam logic [GAP_W-1:0]       GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [NOTE_ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EVAL, S_PLAY, S_GAP, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             song_q, song_d;
    logic [NOTE_ADDR_W-1:0] idx_q, idx_d;
    logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [NOTE_ADDR_W+1:0] rom_addr_q, rom_addr_d;
    logic [6:0]             status_q, status_d;
    logic [3:0]             num_q, num_d;
    logic [3:0]             note_q, note_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [3:0] rom_note;
    logic [3:0] rom_beats;
    logic       rom_is_key;
    logic       song_valid;

    assign rom_note   = bus.rom_data[3:0];
    assign rom_beats  = bus.rom_data[7:4];
    // Codes 8..15 share the rest path with code 0.
    assign rom_is_key = (rom_note != 4'd0) && !rom_note[3];
    assign song_valid = (bus.song_sel >= 4'd1) && (bus.song_sel <= 4'd3);

    function automatic logic [3:0] lowest_key(input logic [6:0] keys);
        logic [3:0] code;
        code = 4'd0;
        for (int k = 6; k >= 0; k--) begin
            if (keys[k]) code = 4'(k + 1);
        end
        return code;
    endfunction

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d    = state_q;
        song_d     = song_q;
        idx_d      = idx_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rom_addr_d = rom_addr_q;
        status_d   = status_q;
        num_d      = num_q;
        note_d     = note_q;

        unique case (state_q)
            S_IDLE: begin
                status_d = bus.key_in;
                num_d    = bus.song_sel;
                note_d   = lowest_key(bus.key_in);
                if (bus.start && !bus.stop && song_valid) begin
                    state_d    = S_FETCH;
                    song_d     = bus.song_sel[1:0];
                    idx_d      = '0;
                    rom_addr_d = {bus.song_sel[1:0], {NOTE_ADDR_W{1'b0}}};
                    status_d   = '0;
                    note_d     = '0;
                end
            end
            S_FETCH: state_d = S_EVAL;
            S_EVAL: begin
                if (rom_beats == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_PLAY;
                    beat_cnt_d = BEAT_W'(rom_beats) * BEAT_K - BEAT_W'(1);
                    status_d   = rom_is_key ? (7'b1 << (rom_note - 4'd1)) : 7'b0;
                    note_d     = rom_is_key ? rom_note : 4'd0;
                end
            end
            S_PLAY: begin
                if (beat_cnt_q == '0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LOAD;
                    status_d  = '0;
                    note_d    = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q - BEAT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_FETCH;
                    idx_d      = idx_q + NOTE_ADDR_W'(1);
                    rom_addr_d = {song_q, idx_d};
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort from any active state drops straight back to idle with the display blanked.
        if (state_q != S_IDLE && bus.stop) begin
            state_d  = S_IDLE;
            status_d = '0;
            note_d   = '0;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            song_q     <= '0;
            idx_q      <= '0;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rom_addr_q <= '0;
            status_q   <= '0;
            num_q      <= '0;
            note_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge value of the others.
            state_q    <= state_d;
            song_q     <= song_d;
            idx_q      <= idx_d;
            beat_cnt_q <= beat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rom_addr_q <= rom_addr_d;
            status_q   <= status_d;
            num_q      <= num_d;
            note_q     <= note_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.status   = status_q;
    assign bus.num      = num_q;
    assign bus.note_out = note_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_song_play_ctrl.sv
// Scoreboard bench for song_play_ctrl: a song-level model expands each started song into
// its per-cycle display trace; a negedge monitor pops and compares while the queue is non-empty.
module tb_song_play_ctrl;
    localparam int BEAT = 4;
    localparam int GAP  = 2;
    localparam int NAW  = 2;

    typedef struct packed {
        logic [6:0] status;
        logic [3:0] note;
        logic [3:0] num;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    song_play_if #(.NOTE_ADDR_W(NAW)) sp ();

    song_play_ctrl #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .NOTE_ADDR_W(NAW)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (sp)
    );

    logic [7:0] rom [16];
    always @(posedge clk) sp.rom_data <= rom[sp.rom_addr];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] key_code(input logic [6:0] k);
        for (int i = 0; i < 7; i++) if (k[i]) return 4'(i + 1);
        return 4'd0;
    endfunction

    function automatic exp_t mk(input logic [6:0] st, input logic [3:0] nt, input int s,
                                input logic dn);
        exp_t e;
        e.status = st;
        e.note   = nt;
        e.num    = 4'(s);
        e.busy   = 1'b1;
        e.done   = dn;
        return e;
    endfunction

    // Song-level model: two silent fetch cycles per word, then the note, then the gap.
    task automatic push_song(input int s);
        logic [7:0] w;
        int         beats;
        int         nt;
        logic [6:0] st;
        logic [3:0] code;
        for (int i = 0; i < 4; i++) begin
            w     = rom[s * 4 + i];
            beats = int'(w[7:4]);
            nt    = int'(w[3:0]);
            sb.push_back(mk('0, '0, s, 1'b0));
            sb.push_back(mk('0, '0, s, 1'b0));
            if (beats == 0) begin
                sb.push_back(mk('0, '0, s, 1'b1));
                return;
            end
            st   = (nt >= 1 && nt <= 7) ? 7'(1 << (nt - 1)) : 7'd0;
            code = (nt >= 1 && nt <= 7) ? 4'(nt) : 4'd0;
            for (int c = 0; c < beats * BEAT; c++) sb.push_back(mk(st, code, s, 1'b0));
            for (int c = 0; c < GAP; c++) sb.push_back(mk('0, '0, s, 1'b0));
        end
        sb.push_back(mk('0, '0, s, 1'b1));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_status", sp.status, e.status);
                check("sb_note", sp.note_out, e.note);
                check("sb_num", sp.num, e.num);
                check("sb_busy", sp.busy, e.busy);
                check("sb_done", sp.done, e.done);
                check("sb_rom_song", sp.rom_addr[3:2], e.num[1:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_song(input int s);
        sp.song_sel = 4'(s);
        sp.start    = 1'b1;
        step();
        sp.start = 1'b0;
        push_song(s);
    endtask

    task automatic drain();
        for (int c = 0; c < 3000 && sb.size() > 0; c++) begin
            sp.key_in   = 7'($urandom);
            sp.song_sel = 4'($urandom);
            step();
        end
        check("drain_timeout", sb.size(), 0);
        check("idle_busy", sp.busy, 0);
        check("idle_done", sp.done, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_status"}, sp.status, 0);
        check({tag, "_note"}, sp.note_out, 0);
        check({tag, "_num"}, sp.num, 0);
        check({tag, "_busy"}, sp.busy, 0);
        check({tag, "_done"}, sp.done, 0);
        check({tag, "_rom_addr"}, sp.rom_addr, 0);
    endtask

    initial begin
        logic [6:0] k;
        logic [3:0] ss;
        logic       done_seen;
        int         s;

        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rst         = 1'b1;
        sp.key_in   = 7'b1010101;
        sp.song_sel = 4'd2;
        sp.start    = 1'b1;
        sp.stop     = 1'b0;
        step();
        step();
        check_zero("reset");

        rst         = 1'b0;
        sp.start    = 1'b0;
        sp.key_in   = 7'b0010100;
        sp.song_sel = 4'd0;
        step();
        check("idle_status", sp.status, 7'b0010100);
        check("idle_note", sp.note_out, 3);
        check("idle_busy0", sp.busy, 0);

        for (int i = 0; i < 4; i++) begin
            k           = 7'($urandom);
            ss          = 4'($urandom);
            sp.key_in   = k;
            sp.song_sel = ss;
            step();
            check("idle_rand_status", sp.status, k);
            check("idle_rand_note", sp.note_out, key_code(k));
            check("idle_rand_num", sp.num, ss);
        end

        rom[8] = 8'h13; rom[9] = 8'h25; rom[10] = 8'h00; rom[11] = 8'h00;
        start_song(2);
        drain();

        sp.key_in = 7'b0000110;
        step();
        step();
        check("after_done_status", sp.status, 7'b0000110);
        check("after_done_note", sp.note_out, 2);

        rom[12] = 8'h20; rom[13] = 8'h1C; rom[14] = 8'h31; rom[15] = 8'h00;
        start_song(3);
        drain();

        for (int i = 0; i < 4; i++) rom[4 + i] = {4'($urandom_range(1, 2)), 4'($urandom)};
        start_song(1);
        drain();

        rom[8] = 8'h34; rom[9] = 8'h21; rom[10] = 8'h00;
        start_song(2);
        repeat (5) step();
        sp.key_in   = 7'b1000000;
        sp.song_sel = 4'd1;
        sp.stop     = 1'b1;
        step();
        sp.stop = 1'b0;
        sb.delete();
        check("stop_busy", sp.busy, 0);
        check("stop_status", sp.status, 0);
        check("stop_note", sp.note_out, 0);
        check("stop_done", sp.done, 0);
        step();
        check("stop_idle_status", sp.status, 7'b1000000);
        check("stop_idle_note", sp.note_out, 7);
        check("stop_idle_num", sp.num, 1);
        done_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            done_seen |= sp.done;
        end
        check("stop_no_done", done_seen, 0);

        sp.song_sel = 4'd1;
        sp.start    = 1'b1;
        sp.stop     = 1'b1;
        step();
        sp.start = 1'b0;
        sp.stop  = 1'b0;
        check("start_stop_busy", sp.busy, 0);
        step();
        check("start_stop_busy2", sp.busy, 0);

        sp.song_sel = 4'd0;
        sp.start    = 1'b1;
        step();
        sp.start = 1'b0;
        check("sel0_busy", sp.busy, 0);
        step();
        check("sel0_busy2", sp.busy, 0);
        sp.song_sel = 4'd5;
        sp.start    = 1'b1;
        step();
        sp.start = 1'b0;
        check("sel5_busy", sp.busy, 0);
        step();
        check("sel5_busy2", sp.busy, 0);

        rom[4] = 8'h21; rom[5] = 8'h13; rom[6] = 8'h00;
        start_song(1);
        repeat (5) step();
        sp.song_sel = 4'd3;
        sp.start    = 1'b1;
        step();
        sp.start = 1'b0;
        drain();

        rom[12] = 8'h35; rom[13] = 8'h22; rom[14] = 8'h00;
        start_song(3);
        repeat (6) step();
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        check_zero("mid_reset");
        step();
        check("mid_reset_busy", sp.busy, 0);

        for (int r = 0; r < 5; r++) begin
            s = int'($urandom_range(1, 3));
            for (int i = 0; i < 4; i++) rom[s * 4 + i] = {4'($urandom_range(0, 2)), 4'($urandom)};
            start_song(s);
            drain();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
